// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with first-word fall-through read, programmable
// almost-full/almost-empty thresholds and sticky error flags (FIFO_ERR_FLAGS_EN).
module fifo_sync_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = LVL_W - 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_fire;
  logic              rd_fire;

  // Flags decode the registered level directly, so they carry no extra latency.
  assign full         = (level == LVL_W'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= LVL_W'(AF_THRESH));
  assign almost_empty = (level <= LVL_W'(AE_THRESH));

  // Acceptance uses the pre-edge flags; clr and a low ena suppress both sides.
  assign wr_fire = ena && !clr && wr_en && !full;
  assign rd_fire = ena && !clr && rd_en && !empty;

  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (ena) begin
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
        if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({wr_fire, rd_fire})
          2'b10:   level <= level + LVL_W'(1);
          2'b01:   level <= level - LVL_W'(1);
          default: level <= level;
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; an empty FIFO masks stale words to zero,
  // which lets the array map onto plain RAM/latch cells.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_en && full)  overflow  <= 1'b1;
        if (rd_en && empty) underflow <= 1'b1;
      end
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param at DATA_W=8, DEPTH=16.
module tb_fifo_sync_param;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       clr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  fifo_sync_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .clr          (clr),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock with the given requests; returns 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check(tag, 32'(rd_data), 32'(exp));
    step(1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    rst_n   = 1'b0;
    ena     = 1'b1;
    clr     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 8'h00;
    #2;
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'h00);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_udf", 32'(underflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. async reset mid-operation clears contents before the next edge
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    check("t1_level3", 32'(level), 32'd3);
    check("t1_head", 32'(rd_data), 32'h11);
    #3 rst_n = 1'b0;
    #1;
    check("t1_rst_level", 32'(level), 32'd0);
    check("t1_rst_empty", 32'(empty), 32'd1);
    check("t1_rst_rd_data", 32'(rd_data), 32'h00);
    #1 rst_n = 1'b1;

    // 2. fill, thresholds, rejected 17th write, drain in order
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      check("t2_level", 32'(level), 32'(i));
      check("t2_af", 32'(almost_full), 32'(i >= 14));
      check("t2_ae", 32'(almost_empty), 32'(i <= 2));
      check("t2_full", 32'(full), 32'(i == 16));
    end
    step(1'b1, 1'b0, 8'hFF);
    check("t2_ovf_level", 32'(level), 32'd16);
    check("t2_ovf_head", 32'(rd_data), 32'h01);
    check("t2_ovf_flag", 32'(overflow), 32'(ERR_EN));
    for (int i = 1; i <= 16; i++) pop_expect("t2_drain", 8'(i));
    check("t2_empty", 32'(empty), 32'd1);
    check("t2_udf_clear", 32'(underflow), 32'd0);

    // 3. pointer wrap
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 10; i++) pop_expect("t3_pre", 8'(8'h30 + i));
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'(8'hA0 + i));
    check("t3_level12", 32'(level), 32'd12);
    for (int i = 0; i < 12; i++) pop_expect("t3_wrap", 8'(8'hA0 + i));
    check("t3_level0", 32'(level), 32'd0);

    // 4. simultaneous read/write at empty, mid level and full
    clr = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    clr = 1'b0;
    check("t4_clr_ovf", 32'(overflow), 32'd0);
    step(1'b1, 1'b1, 8'h55);
    check("t4_l0_level", 32'(level), 32'd1);
    check("t4_l0_head", 32'(rd_data), 32'h55);
    check("t4_l0_udf", 32'(underflow), 32'(ERR_EN));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h56 + i));
    check("t4_l5_pre", 32'(level), 32'd5);
    step(1'b1, 1'b1, 8'h5A);
    check("t4_l5_level", 32'(level), 32'd5);
    check("t4_l5_head", 32'(rd_data), 32'h56);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'(8'h5B + i));
    check("t4_l16_pre", 32'(full), 32'd1);
    step(1'b1, 1'b1, 8'hEE);
    check("t4_l16_level", 32'(level), 32'd15);
    check("t4_l16_ovf", 32'(overflow), 32'(ERR_EN));
    for (int i = 0; i < 15; i++) pop_expect("t4_order", 8'(8'h57 + i));
    check("t4_final_empty", 32'(empty), 32'd1);

    // 5. ena freeze and clr priority
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h70 + i));
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 8'hC0);
      check("t5_frz_level", 32'(level), 32'd7);
      check("t5_frz_head", 32'(rd_data), 32'h70);
    end
    clr = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    check("t5_frz_clr", 32'(level), 32'd7);
    ena = 1'b1;
    step(1'b1, 1'b0, 8'hC1);
    clr = 1'b0;
    check("t5_clr_level", 32'(level), 32'd0);
    check("t5_clr_empty", 32'(empty), 32'd1);
    check("t5_clr_rd_data", 32'(rd_data), 32'h00);
    check("t5_clr_ovf", 32'(overflow), 32'd0);
    check("t5_clr_udf", 32'(underflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
